// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared EX-stage types for the iterative multiply/divide unit
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } iter_md_state_e;

endpackage

// File: rtl/ibex_ex_iter_unit.sv
// rtl/ibex_ex_iter_unit.sv - one-bit-per-cycle multiply/divide unit with handshakes and kill
module ibex_ex_iter_unit
    import ibex_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter bit          EarlyOut = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  md_op_e           op_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(Width);

    iter_md_state_e     state_q;
    md_op_e             op_q;
    logic [1:0]         smode_q;
    logic [Width-1:0]   opa_q;
    logic [Width-1:0]   opb_q;
    logic               early_q;
    logic [Width-1:0]   mag_q;
    logic [2*Width-1:0] acc_q;
    logic [CntW-1:0]    cnt_q;
    logic               sign_q;
    logic               div0_q;
    logic               valid_q;
    logic [Width-1:0]   result_q;

    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [Width-1:0]   a_mag;
    logic [Width-1:0]   b_mag;
    logic               zero_a;
    logic               zero_b;
    logic               early_hit;
    logic [Width-1:0]   early_res;
    logic [Width:0]     mul_sum;
    logic [Width:0]     div_trial;
    logic               div_ge;
    logic [Width-1:0]   div_rem;
    logic [2*Width-1:0] acc_iter;
    logic [2*Width-1:0] prod_fix;
    logic [Width-1:0]   quo_fix;
    logic [Width-1:0]   rem_fix;
    logic [Width-1:0]   fix_sel;

    assign is_div    = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    assign a_neg     = smode_q[0] & opa_q[Width-1];
    assign b_neg     = smode_q[1] & opb_q[Width-1];
    assign a_mag     = a_neg ? (~opa_q + 1'b1) : opa_q;
    assign b_mag     = b_neg ? (~opb_q + 1'b1) : opb_q;
    assign zero_a    = (opa_q == '0);
    assign zero_b    = (opb_q == '0);
    assign early_hit = early_q & (is_div ? zero_b : (zero_a | zero_b));
    assign early_res = !is_div ? '0 : ((op_q == MD_OP_DIV) ? '1 : opa_q);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
    assign div_trial = {acc_q[2*Width-1:Width], acc_q[Width-1]} - {1'b0, mag_q};
    assign div_ge    = ~div_trial[Width];
    assign div_rem   = div_ge ? div_trial[Width-1:0] : {acc_q[2*Width-2:Width], acc_q[Width-1]};
    assign acc_iter  = is_div ? {div_rem, acc_q[Width-2:0], div_ge}
                              : {mul_sum, acc_q[Width-1:1]};

    assign prod_fix  = sign_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix   = sign_q ? (~acc_q[Width-1:0] + 1'b1) : acc_q[Width-1:0];
    assign rem_fix   = sign_q ? (~acc_q[2*Width-1:Width] + 1'b1) : acc_q[2*Width-1:Width];

    always_comb begin
        fix_sel = '0;
        case (op_q)
            MD_OP_MULL: fix_sel = prod_fix[Width-1:0];
            MD_OP_MULH: fix_sel = prod_fix[2*Width-1:Width];
            MD_OP_DIV:  fix_sel = div0_q ? '1 : quo_fix;
            MD_OP_REM:  fix_sel = div0_q ? opa_q : rem_fix;
            default:    fix_sel = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= MD_OP_MULL;
            smode_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            early_q  <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            div0_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_i;
                        smode_q <= signed_mode_i;
                        opa_q   <= op_a_i;
                        opb_q   <= op_b_i;
                        early_q <= EarlyOut & ~data_ind_timing_i;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    sign_q <= (op_q == MD_OP_REM) ? a_neg : (a_neg ^ b_neg);
                    div0_q <= is_div & zero_b;
                    cnt_q  <= CntW'(Width - 1);
                    mag_q  <= is_div ? b_mag : a_mag;
                    acc_q  <= {{Width{1'b0}}, (is_div ? a_mag : b_mag)};
                    if (early_hit) begin
                        result_q <= early_res;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_iter;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= fix_sel;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ibex_ex_iter_unit.sv
// tb/tb_ibex_ex_iter_unit.sv - vector table, random ops vs arithmetic model, kill/backpressure/reset sequences
module tb_ibex_ex_iter_unit;
    import ibex_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    md_op_e       op_i = MD_OP_MULL;
    logic [1:0]   signed_mode_i = 2'b00;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         data_ind_timing_i = 1'b0;
    logic         kill_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] result_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    ibex_ex_iter_unit #(.Width(W), .EarlyOut(1'b1)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .op_i              (op_i),
        .signed_mode_i     (signed_mode_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .data_ind_timing_i (data_ind_timing_i),
        .kill_i            (kill_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .result_o          (result_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        md_op_e      op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input md_op_e op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
        longint av, bv, p, q, r;
        logic [63:0] pv;
        av = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
        bv = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
        if (op == MD_OP_MULL || op == MD_OP_MULH) begin
            p  = av * bv;
            pv = p;
            return (op == MD_OP_MULL) ? pv[31:0] : pv[63:32];
        end
        if (b == 32'd0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
        q = av / bv;
        r = av % bv;
        pv = (op == MD_OP_DIV) ? q : r;
        return pv[31:0];
    endfunction

    function automatic int model_lat(input md_op_e op, input logic [31:0] a,
                                     input logic [31:0] b, input logic dit);
        logic is_mul;
        is_mul = (op == MD_OP_MULL || op == MD_OP_MULH);
        if (!dit && ((is_mul && (a == 0 || b == 0)) || (!is_mul && b == 0))) return 2;
        return W + 3;
    endfunction

    task automatic accept(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                          input logic [31:0] b, input logic dit);
        valid_i = 1'b1;
        op_i = op;
        signed_mode_i = sm;
        op_a_i = a;
        op_b_i = b;
        data_ind_timing_i = dit;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        op_a_i = $urandom;
        op_b_i = $urandom;
        signed_mode_i = 2'($urandom);
        data_ind_timing_i = 1'($urandom);
    endtask

    task automatic run_op(input string name, input md_op_e op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input logic dit,
                          input logic [31:0] exp);
        int c;
        logic rdy_seen;
        accept(op, sm, a, b, dit);
        c = 1;
        rdy_seen = 1'b0;
        while (!valid_o && c < 100) begin
            if (ready_o || !busy_o) rdy_seen = 1'b1;
            @(posedge clk_i);
            #1;
            c++;
        end
        chk($sformatf("%s latency", name), c, model_lat(op, a, b, dit));
        chk($sformatf("%s result", name), result_o, exp);
        chk($sformatf("%s ready_while_busy", name), rdy_seen, 1'b0);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk($sformatf("%s release", name), {valid_o, ready_o, busy_o}, 3'b010);
    endtask

    initial begin
        tbl[0]  = '{MD_OP_MULL, 2'b11, 32'd7,         32'd6,         1'b0, 32'h0000_002A};
        tbl[1]  = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        tbl[2]  = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE};
        tbl[3]  = '{MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        tbl[4]  = '{MD_OP_MULH, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        tbl[5]  = '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD};
        tbl[6]  = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF};
        tbl[7]  = '{MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000};
        tbl[8]  = '{MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        tbl[9]  = '{MD_OP_DIV,  2'b00, 32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF};
        tbl[10] = '{MD_OP_REM,  2'b00, 32'd5,         32'd0,         1'b0, 32'h0000_0005};
        tbl[11] = '{MD_OP_DIV,  2'b00, 32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF};
        tbl[12] = '{MD_OP_REM,  2'b00, 32'd5,         32'd0,         1'b1, 32'h0000_0005};
        tbl[13] = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd0,         1'b0, 32'hFFFF_FFF9};
        tbl[14] = '{MD_OP_MULL, 2'b11, 32'd0,         32'd12345,     1'b0, 32'h0000_0000};

        #1;
        chk("reset_state", {ready_o, valid_o, busy_o, result_o}, {3'b100, 32'h0});
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sm, tbl[i].a, tbl[i].b,
                   tbl[i].dit, tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            md_op_e op;
            logic [1:0] sm;
            logic [31:0] a, b;
            logic dit;
            logic [31:0] pick[4];
            op  = md_op_e'($urandom_range(0, 3));
            sm  = 2'($urandom);
            dit = 1'($urandom);
            pick[0] = 32'd0;
            pick[1] = 32'h8000_0000;
            pick[2] = 32'hFFFF_FFFF;
            pick[3] = $urandom_range(1, 20);
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            run_op($sformatf("rnd%0d", i), op, sm, a, b, dit, model(op, sm, a, b));
        end

        // Kill in IDLE blocks the accept.
        valid_i = 1'b1;
        kill_i = 1'b1;
        op_i = MD_OP_MULL;
        op_a_i = 32'd3;
        op_b_i = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        kill_i = 1'b0;
        chk("kill_idle_no_accept", {ready_o, busy_o}, 2'b10);

        // Kill in cycle 10 of a divide, then a fresh multiply in cycle 11.
        begin
            logic v_seen;
            v_seen = 1'b0;
            accept(MD_OP_DIV, 2'b11, 32'd1000, 32'd7, 1'b1);
            for (int c = 1; c < 10; c++) begin
                if (valid_o) v_seen = 1'b1;
                @(posedge clk_i);
                #1;
            end
            kill_i = 1'b1;
            @(posedge clk_i);
            #1;
            kill_i = 1'b0;
            chk("kill_mid_div", {v_seen, valid_o, ready_o, busy_o}, 4'b0010);
            run_op("after_kill", MD_OP_MULL, 2'b11, 32'd3, 32'd3, 1'b0, 32'd9);
        end

        // Backpressure: result and valid hold while ready_i is low.
        begin
            int c;
            logic [31:0] r0, ea, eb;
            ea = $urandom;
            eb = $urandom;
            accept(MD_OP_MULH, 2'b01, ea, eb, 1'b1);
            c = 1;
            while (!valid_o && c < 100) begin
                @(posedge clk_i);
                #1;
                c++;
            end
            chk("bp_latency", c, W + 3);
            chk("bp_result", result_o, model(MD_OP_MULH, 2'b01, ea, eb));
            r0 = result_o;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk_i);
                #1;
                chk($sformatf("bp_hold%0d", k), {valid_o, result_o}, {1'b1, r0});
            end
            ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            ready_i = 1'b0;
            chk("bp_release", {valid_o, ready_o}, 2'b01);
        end

        // Asynchronous reset in the middle of ITER.
        accept(MD_OP_DIV, 2'b00, 32'd77, 32'd5, 1'b1);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk_i);
            #1;
        end
        chk("pre_reset_busy", {busy_o, ready_o}, 2'b10);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", {valid_o, ready_o, busy_o, result_o}, {3'b010, 32'h0});
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        run_op("after_reset", MD_OP_DIV, 2'b00, 32'd77, 32'd5, 1'b0, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
